// File: rtl/fft_out_reorder.sv
// fft_out_reorder: bit-reversed to natural-order reorder buffer
// for the 4-lane FFT output, ping-pong banks, 4 bins per beat.
module fft_out_reorder #(
   parameter int NBITS_out = 28,
   parameter int N         = 128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2*NBITS_out-1:0] fftIn0_up,
   input  logic [2*NBITS_out-1:0] fftIn0_down,
   input  logic [2*NBITS_out-1:0] fftIn1_up,
   input  logic [2*NBITS_out-1:0] fftIn1_down,
   input  logic                   in_valid,
   input  logic                   in_sof,
   output logic [2*NBITS_out-1:0] fftOut0_up,
   output logic [2*NBITS_out-1:0] fftOut0_down,
   output logic [2*NBITS_out-1:0] fftOut1_up,
   output logic [2*NBITS_out-1:0] fftOut1_down,
   output logic                   out_valid,
   output logic                   out_sof,
   output logic                   frame_err
);

   localparam int W    = 2 * NBITS_out;
   localparam int LOGN = $clog2(N);
   localparam int NB   = N / 4;
   localparam int BW   = LOGN - 2;

   typedef enum logic {
      IDLE,
      READ
   } state_t;

   logic [W-1:0]  mem [2*N];
   logic [W-1:0]  din [4];

   logic          armed;
   logic [BW-1:0] wcnt;
   logic          wbank;
   logic [1:0]    full;

   logic          wr_en;
   logic [BW-1:0] wbeat;
   logic          wr_last;

   state_t        state;
   state_t        state_n;
   logic          rbank;
   logic [BW-1:0] rcnt;
   logic          rd_en;
   logic          rd_last;

   function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
      logic [LOGN-1:0] r;
      r = '0;
      for (int i = 0; i < LOGN; i++)
         r[i] = a[LOGN-1-i];
      return r;
   endfunction

   assign din[0] = fftIn0_up;
   assign din[1] = fftIn0_down;
   assign din[2] = fftIn1_up;
   assign din[3] = fftIn1_down;

   // write decode: sof forces beat 0, beats before first sof are dropped
   always_comb begin
      wr_en   = in_valid & (in_sof | armed);
      wbeat   = in_sof ? '0 : wcnt;
      wr_last = wr_en & (wbeat == BW'(NB - 1));
   end

   // scatter each lane to its bit-reversed bin slot in the write bank
   always_ff @(posedge clk) begin
      if (wr_en)
         for (int l = 0; l < 4; l++)
            mem[{wbank, bitrev({wbeat, 2'(l)})}] <= din[l];
   end

   // writer beat counter, bank select and resync error pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armed     <= 1'b0;
         wcnt      <= '0;
         wbank     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= in_valid & in_sof & armed & (wcnt != '0);
         if (in_valid & in_sof)
            armed <= 1'b1;
         if (wr_en) begin
            wcnt <= wr_last ? '0 : wbeat + 1'b1;
            if (wr_last)
               wbank <= ~wbank;
         end
      end
   end

   // bank-full flags: set by writer on completion, cleared after drain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full <= '0;
      end else begin
         if (wr_last)
            full[wbank] <= 1'b1;
         if (rd_en & rd_last)
            full[rbank] <= 1'b0;
      end
   end

   // reader state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   // reader next state: chain straight into a pending full bank
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (full[rbank]) state_n = READ;
         READ: if (rd_last) state_n = full[~rbank] ? READ : IDLE;
      endcase
   end

   // reader control: a beat is read whenever a frame is in progress
   always_comb begin
      rd_en   = (state == READ) | ((state == IDLE) & full[rbank]);
      rd_last = (rcnt == BW'(NB - 1));
   end

   // reader beat counter and bank select
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rcnt  <= '0;
         rbank <= 1'b0;
      end else if (rd_en) begin
         rcnt <= rd_last ? '0 : rcnt + 1'b1;
         if (rd_last)
            rbank <= ~rbank;
      end
   end

   // registered outputs; data holds when no beat is emitted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid    <= 1'b0;
         out_sof      <= 1'b0;
         fftOut0_up   <= '0;
         fftOut0_down <= '0;
         fftOut1_up   <= '0;
         fftOut1_down <= '0;
      end else begin
         out_valid <= rd_en;
         out_sof   <= rd_en & (rcnt == '0);
         if (rd_en) begin
            fftOut0_up   <= mem[{rbank, rcnt, 2'd0}];
            fftOut0_down <= mem[{rbank, rcnt, 2'd1}];
            fftOut1_up   <= mem[{rbank, rcnt, 2'd2}];
            fftOut1_down <= mem[{rbank, rcnt, 2'd3}];
         end
      end
   end

endmodule
